// File: rtl/icache_axi_rd_if.sv
// Bundle of the icache-side fill request and the AXI4 AR/R read channels.
// master = the fill engine, slave = the icache plus interconnect/memory side.
interface icache_axi_rd_if #(
    parameter int LINE_WORDS = 8
);
    logic                       rreq_i;
    logic [31:0]                raddr_i;
    logic                       rend_o;
    logic [LINE_WORDS*32-1:0]   cacheline_rdata_o;
    logic                       resp_err_o;

    // Valid/ready: a transfer happens on a rising edge where both are 1;
    // the sender keeps valid and payload stable until then.
    logic [3:0]                 arid;
    logic [31:0]                araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic                       arvalid;
    logic                       arready;

    logic [3:0]                 rid;
    logic [31:0]                rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport master (
        input  rreq_i, raddr_i, arready, rid, rdata, rresp, rlast, rvalid,
        output rend_o, cacheline_rdata_o, resp_err_o,
               arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output rreq_i, raddr_i, arready, rid, rdata, rresp, rlast, rvalid,
        input  rend_o, cacheline_rdata_o, resp_err_o,
               arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/icache_axi_rd.sv
// Instruction-cache line-fill engine: one AXI4 INCR read burst per request,
// beats gathered into a line register and handed back with a one-cycle rend_o.
module icache_axi_rd #(
    parameter int          LINE_WORDS = 8,
    parameter logic [3:0]  ARID_VAL   = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    icache_axi_rd_if.master       bus,
    output logic [2:0]            state_dbg_o
);
    localparam int              CW       = $clog2(LINE_WORDS);
    localparam logic [31:0]     OFF_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_DONE = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e                      state_q, state_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic                        rend_q, rend_d;
    logic                        resp_err_q, resp_err_d;
    logic                        err_q, err_d;
    logic [31:0]                 araddr_q, araddr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][31:0] line_q, line_d;
    logic                        beat_ok;

    // Beats tagged with another ID are drained (rready is high) but ignored.
    assign beat_ok = bus.rvalid & rready_q & (bus.rid == ARID_VAL);

    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rend_d     = 1'b0;
        resp_err_d = 1'b0;
        err_d      = err_q;
        araddr_d   = araddr_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rreq_i) begin
                    araddr_d  = bus.raddr_i & ~OFF_MASK;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (beat_ok) begin
                    line_d[cnt_q] = bus.rdata;
                    // Overlong bursts keep rewriting the last word.
                    if (cnt_q != LAST_IDX) cnt_d = cnt_q + CW'(1);
                    if (bus.rresp != 2'b00) err_d = 1'b1;
                    if (bus.rlast) begin
                        rready_d   = 1'b0;
                        rend_d     = 1'b1;
                        resp_err_d = err_d;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rend_q     <= 1'b0;
            resp_err_q <= 1'b0;
            err_q      <= 1'b0;
            araddr_q   <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rend_q     <= rend_d;
            resp_err_q <= resp_err_d;
            err_q      <= err_d;
            araddr_q   <= araddr_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
        end
    end

    assign bus.arid              = ARID_VAL;
    assign bus.araddr            = araddr_q;
    assign bus.arlen             = 8'(LINE_WORDS - 1);
    assign bus.arsize            = 3'b010;
    assign bus.arburst           = 2'b01;
    assign bus.arvalid           = arvalid_q;
    assign bus.rready            = rready_q;
    assign bus.rend_o            = rend_q;
    assign bus.resp_err_o        = resp_err_q;
    assign bus.cacheline_rdata_o = line_q;
    assign state_dbg_o           = state_q;
endmodule

// File: tb/tb_icache_axi_rd.sv
// Directed-plus-random bench for icache_axi_rd: acts as icache and AXI slave,
// predicting each filled line from the beats it sends.
module tb_icache_axi_rd;
    localparam int          LW  = 8;
    localparam logic [3:0]  AID = 4'd5;
    localparam logic [31:0] OFF = 32'(LW * 4 - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        state_dbg;
    int                n_assert = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic [LW*32-1:0]  exp_line = '0;

    icache_axi_rd_if #(.LINE_WORDS(LW)) bus ();

    icache_axi_rd #(.LINE_WORDS(LW), .ARID_VAL(AID)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [LW*32-1:0] obs, input logic [LW*32-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_arvalid"},  bus.arvalid, 0);
        chk({tag, "_rready"},   bus.rready, 0);
        chk({tag, "_rend"},     bus.rend_o, 0);
        chk({tag, "_resp_err"}, bus.resp_err_o, 0);
        chk({tag, "_araddr"},   bus.araddr, 0);
        chk({tag, "_line"},     bus.cacheline_rdata_o, 0);
    endtask

    // One complete fill as seen from outside; the model is the list of
    // accepted beats folded into exp_line (index clamps at the last word).
    task automatic fill(input logic [31:0] addr, input int n_beats, input int ar_stall,
                        input int gap_pct, input int foreign_at, input int err_at,
                        input bit seq_data, input bit check_lat, input bit hold_req);
        logic [31:0] exp_addr;
        logic [31:0] d;
        bit          exp_err;
        bit          done;
        int          t_start, n, i, slot, idx;
        exp_err  = 1'b0;
        exp_addr = addr & ~OFF;
        bus.rreq_i  = 1'b1;
        bus.raddr_i = addr;
        t_start = cyc;
        n = 0;
        while (bus.arvalid !== 1'b1 && n < 8) begin
            cycle();
            n++;
        end
        chk("ar_valid_seen", bus.arvalid, 1);
        bus.raddr_i = $urandom;
        chk("araddr", bus.araddr, exp_addr);
        chk("arlen", bus.arlen, LW - 1);
        chk("arsize", bus.arsize, 3'b010);
        chk("arburst", bus.arburst, 2'b01);
        chk("arid", bus.arid, AID);
        chk("rready_in_ar", bus.rready, 0);
        for (int s = 0; s < ar_stall; s++) begin
            cycle();
            chk("ar_stall_valid", bus.arvalid, 1);
            chk("ar_stall_addr", bus.araddr, exp_addr);
            chk("ar_stall_len", bus.arlen, LW - 1);
        end
        bus.arready = 1'b1;
        cycle();
        bus.arready = 1'b0;
        chk("arvalid_after_hs", bus.arvalid, 0);
        chk("rready_in_r", bus.rready, 1);
        i = 0;
        slot = 0;
        done = 1'b0;
        while (!done && slot < 400) begin
            if (slot == foreign_at) begin
                bus.rvalid = 1'b1;
                bus.rid    = AID ^ 4'd1;
                bus.rdata  = $urandom;
                bus.rresp  = 2'b10;
                bus.rlast  = 1'b1;
            end else if ($urandom_range(99) < gap_pct) begin
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
            end else begin
                d = seq_data ? 32'hA0 + 32'(i) : $urandom;
                bus.rvalid = 1'b1;
                bus.rid    = AID;
                bus.rdata  = d;
                bus.rresp  = (i == err_at) ? 2'b10 : 2'b00;
                bus.rlast  = (i == n_beats - 1);
                idx = (i < LW) ? i : LW - 1;
                exp_line[idx*32 +: 32] = d;
                if (i == err_at) exp_err = 1'b1;
                if (i == n_beats - 1) done = 1'b1;
                i++;
            end
            cycle();
            slot++;
            if (!done) chk("no_early_rend", bus.rend_o, 0);
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        chk("rend_pulse", bus.rend_o, 1);
        chk("resp_err", bus.resp_err_o, exp_err);
        chk("line", bus.cacheline_rdata_o, exp_line);
        chk("rready_done", bus.rready, 0);
        if (check_lat) chk("latency", cyc - t_start, LW + 2);
        if (!hold_req) bus.rreq_i = 1'b0;
        cycle();
        chk("rend_single", bus.rend_o, 0);
        chk("resp_err_clear", bus.resp_err_o, 0);
        chk("gap_arvalid", bus.arvalid, 0);
        chk("line_hold", bus.cacheline_rdata_o, exp_line);
        cycle();
        chk("idle_arvalid", bus.arvalid, 0);
        if (hold_req) begin
            cycle();
            chk("second_ar", bus.arvalid, 1);
            chk("second_araddr", bus.araddr, bus.raddr_i & ~OFF);
        end
    endtask

    initial begin
        bus.rreq_i  = 1'b0;
        bus.raddr_i = '0;
        bus.arready = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        bus.rvalid  = 1'b0;
        repeat (3) cycle();
        chk_reset_values("rst_hold");
        rst = 1'b0;
        cycle();
        chk_reset_values("post_rst");

        // Directed line fill with known data and minimum latency.
        fill(32'h1FC0_0014, LW, 0, 0, -1, -1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < LW; k++)
            chk("word_seq", bus.cacheline_rdata_o[k*32 +: 32], 32'hA0 + 32'(k));

        // AR back-pressure, then gapped R with a foreign-ID beat.
        fill($urandom, LW, 5, 0, -1, -1, 1'b0, 1'b0, 1'b0);
        fill($urandom, LW, $urandom_range(3), 30, 2, -1, 1'b0, 1'b0, 1'b0);

        // Error on the third beat, then a clean fill.
        fill($urandom, LW, 0, 0, -1, 2, 1'b0, 1'b0, 1'b0);
        fill($urandom, LW, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0);

        // Early rlast keeps older words; overlong burst rewrites the last word.
        fill($urandom, 3, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0);
        fill($urandom, LW + 3, 0, 10, -1, LW + 1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a burst.
        bus.rreq_i  = 1'b1;
        bus.raddr_i = $urandom;
        cycle();
        bus.arready = 1'b1;
        cycle();
        bus.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.rvalid = 1'b1;
            bus.rid    = AID;
            bus.rdata  = $urandom;
            bus.rresp  = 2'b00;
            bus.rlast  = 1'b0;
            cycle();
        end
        #2 rst = 1'b1;
        #1 chk_reset_values("async_rst");
        bus.rvalid = 1'b0;
        bus.rreq_i = 1'b0;
        exp_line   = '0;
        cycle();
        chk("rst_no_rend", bus.rend_o, 0);
        rst = 1'b0;
        cycle();
        fill($urandom, LW, 1, 20, -1, -1, 1'b0, 1'b0, 1'b0);

        // Request held across DONE/GAP: one burst, next AR only after GAP.
        fill($urandom, LW, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1);
        bus.rreq_i = 1'b0;
        rst = 1'b1;
        cycle();
        chk_reset_values("rst_after_hold");
        exp_line = '0;
        rst = 1'b0;
        cycle();

        // Random fills.
        for (int r = 0; r < 6; r++)
            fill($urandom, $urandom_range(1, LW + 2), $urandom_range(3), $urandom_range(40),
                 ($urandom_range(1) == 1) ? int'($urandom_range(3)) : -1,
                 ($urandom_range(1) == 1) ? int'($urandom_range(LW - 1)) : -1,
                 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_axi_rd.md
ICACHE_AXI_RD -- requirements
Module: icache_axi_rd

Interface
REQ-001 Parameter LINE_WORDS, default 8, 32-bit words per cache line (power of 2, 2..16).
REQ-002 Parameter ARID_VAL, default 4'd0, AXI read ID driven on arid and matched on rid.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rreq_i  input  1  line-fill request from icache; held high until rend_o.
REQ-006 raddr_i  input  32  physical fill address; captured at acceptance.
REQ-007 rend_o  output  1  one-cycle pulse; line data valid.
REQ-008 cacheline_rdata_o  output  LINE_WORDS*32  filled line; word k at bits [32k+31:32k].
REQ-009 resp_err_o  output  1  pulses with rend_o if any accepted beat had rresp != 0.
REQ-010 arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1: outputs; arready 1: input (AXI4 AR channel).
REQ-011 rid 4, rdata 32, rresp 2, rlast 1, rvalid 1: inputs; rready 1: output (AXI4 R channel).

Function
REQ-012 States: IDLE, AR, R, DONE, GAP.
REQ-013 IDLE: rreq_i=1 -> capture address, clear beat counter and error flag, go AR; otherwise stay.
REQ-014 Captured address = raddr_i with low log2(LINE_WORDS*4) bits forced to 0.
REQ-015 AR: arvalid=1; araddr=captured address; arlen=LINE_WORDS-1; arsize=3'b010; arburst=2'b01 (INCR); arid=ARID_VAL.
REQ-016 AR payload is stable while arvalid=1 and arready=0; arvalid&arready -> go R next cycle.
REQ-017 arvalid is 0 in every state except AR.
REQ-018 R: rready=1; rready is 0 in every other state.
REQ-019 Beat accepted when rvalid&rready&(rid==ARID_VAL); beats with other rid are consumed but discarded.
REQ-020 Accepted beat writes rdata into word[beat counter]; counter increments and saturates at LINE_WORDS-1; further beats overwrite the last word.
REQ-021 An accepted beat with rresp != 2'b00 sets the error flag.
REQ-022 An accepted beat with rlast=1 -> go DONE, regardless of counter value.
REQ-023 DONE: rend_o=1 and resp_err_o=error flag for exactly one cycle; cacheline_rdata_o holds the complete line; go GAP.
REQ-024 GAP: one cycle, rreq_i ignored; go IDLE.
REQ-025 cacheline_rdata_o holds its last value until the first beat of the next fill.
REQ-026 Latency: rend_o asserts 1 cycle after the rlast beat; minimum rreq_i-to-rend_o latency is LINE_WORDS+2 cycles with arready=1 and rvalid=1 every cycle.
REQ-027 raddr_i changes after acceptance have no effect on the outstanding fill.
REQ-028 At most one burst is outstanding at any time.

Reset
REQ-029 rst=1 forces IDLE immediately, independent of clk.
REQ-030 Reset values: arvalid=0, rready=0, rend_o=0, resp_err_o=0, araddr=0, cacheline_rdata_o=0, beat counter=0.
REQ-031 Reset mid-burst abandons the burst with no rend_o. Clearing outstanding interconnect beats is the system's responsibility.

Verification
REQ-032 rreq_i=1, raddr_i=0x1FC0_0014, arready=1, 8 beats rdata=0xA0..0xA7, rlast on beat 8 -> araddr=0x1FC0_0000, arlen=7, rend_o at cycle 10, word k=0xA0+k, resp_err_o=0.
REQ-033 arready held 0 for 5 cycles -> arvalid stays 1 with araddr/arlen stable; burst proceeds after arready=1.
REQ-034 rvalid gaps between beats, plus one beat with rid != ARID_VAL -> foreign beat discarded; line correct; single rend_o pulse.
REQ-035 Beat 3 has rresp=2'b10 -> line completes; rend_o=1 with resp_err_o=1. Next fill with clean beats -> resp_err_o=0.
REQ-036 rst asserted after beat 4 -> arvalid=rready=rend_o=0 at once; cacheline_rdata_o=0. A new rreq_i after rst release -> normal fill.
REQ-037 rreq_i held high through DONE -> exactly one burst per request. With rreq_i still high after GAP, a second AR is issued one cycle after GAP.
